// File: rtl/vedic_exec.sv
// Execute/write-back stage: single-cycle 32-bit add or 4-step 16x16 Urdhva-Tiryakbhyam
// multiply, followed by a one-cycle write-back strobe to registers t0..t8 (index 1..9).
module vedic_exec #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [RADDR-1:0] store,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [RADDR-1:0] wb_addr,
  output logic             wb_en,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [2:0] FUNC_ADD = 3'd1;
  localparam logic [2:0] FUNC_MPY = 3'd2;

  state_t           state, state_next;
  logic [15:0]      a_q, b_q;
  logic [RADDR-1:0] store_q;
  logic [WIDTH-1:0] acc;
  logic [1:0]       cnt;
  logic             accept;
  logic [7:0]       op_x, op_y;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] partial;

  // 4x4 Urdhva cell: vertical/crosswise column sums, then weighted by column position.
  function automatic logic [7:0] urdhva4(input logic [3:0] x, input logic [3:0] y);
    logic [2:0] col [7];
    logic [7:0] p;
    for (int c = 0; c < 7; c++) col[c] = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        col[i+j] = col[i+j] + 3'(x[i] & y[j]);
    p = '0;
    for (int c = 0; c < 7; c++) p = p + (8'(col[c]) << c);
    return p;
  endfunction

  function automatic logic [15:0] urdhva8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, lh, hl, hh;
    ll = urdhva4(x[3:0], y[3:0]);
    lh = urdhva4(x[3:0], y[7:4]);
    hl = urdhva4(x[7:4], y[3:0]);
    hh = urdhva4(x[7:4], y[7:4]);
    return 16'(ll) + (16'(lh) << 4) + (16'(hl) << 4) + (16'(hh) << 8);
  endfunction

  function automatic logic store_ok(input logic [RADDR-1:0] s);
    return (s >= RADDR'(1)) && (s <= RADDR'(9));
  endfunction

  assign accept = in_valid && in_ready && (func == FUNC_ADD || func == FUNC_MPY);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (func == FUNC_MPY) ? MUL : DONE;
      MUL:     if (cnt == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == MUL) || (state == DONE);
  end

  // Step operand select: lo*lo, lo*hi<<8, hi*lo<<8, hi*hi<<16.
  always_comb begin
    op_x  = a_q[7:0];
    op_y  = b_q[7:0];
    shamt = 5'd0;
    case (cnt)
      2'd1: begin op_y = b_q[15:8]; shamt = 5'd8; end
      2'd2: begin op_x = a_q[15:8]; shamt = 5'd8; end
      2'd3: begin op_x = a_q[15:8]; op_y = b_q[15:8]; shamt = 5'd16; end
      default: ;
    endcase
    partial = WIDTH'(urdhva8(op_x, op_y)) << shamt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      store_q <= '0;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
      wb_addr <= '0;
      wb_en   <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          a_q     <= data_a[15:0];
          b_q     <= data_b[15:0];
          store_q <= store;
          if (func == FUNC_ADD) begin
            result  <= data_a + data_b;
            wb_addr <= store;
            wb_en   <= store_ok(store);
          end else begin
            acc <= '0;
            cnt <= '0;
          end
        end
        MUL: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            result  <= acc + partial;
            wb_addr <= store_q;
            wb_en   <= store_ok(store_q);
          end else begin
            acc <= acc + partial;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
